// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_SAMPLE  = 7;
    localparam int LAST_SAMPLE = 15;
    localparam int DATA_BITS   = 7;

endpackage : uart_pkg

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-clk tick every CLK_DIV system clocks.
module baud_tick_gen #(
    parameter int unsigned CLK_DIV = 27
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: wrap to zero after the tick cycle.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Divider register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

endmodule : baud_tick_gen

// File: rtl/uart_rx7.sv
// 7-bit UART receiver: 16x oversampling, optional even parity, one stop bit.
module uart_rx7
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 27,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_done_tick,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    logic tick;

    baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_e            state_q,     state_d;
    logic [3:0]           s_q,         s_d;
    logic [2:0]           n_q,         n_d;
    logic [DATA_BITS-1:0] b_q,         b_d;
    logic                 p_err_q,     p_err_d;
    logic                 line_high_q, line_high_d;
    logic [DATA_BITS-1:0] data_q,      data_d;
    logic                 perr_q,      perr_d;
    logic                 ferr_q,      ferr_d;
    logic                 done_q,      done_d;

    assign rx_s         = sync_q[1];
    assign data         = data_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: synchronizer resets to 1 so an idle line is not mistaken for a start bit after reset.
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Next-state and datapath decisions for the receive FSM.
    always_comb begin
        // NOTE: every value driven here gets a default first, otherwise a latch is inferred.
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        p_err_d     = p_err_q;
        line_high_d = line_high_q;
        data_d      = data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A start is a fall on a line that has been seen high since the last frame.
                if (rx_s) begin
                    line_high_d = 1'b1;
                end else if (line_high_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'(MID_SAMPLE)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'(LAST_SAMPLE)) begin
                        b_d = {rx_s, b_q[DATA_BITS-1:1]};
                        s_d = '0;
                        if (n_q == 3'(DATA_BITS - 1)) begin
                            state_d = PARITY_EN ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (s_q == 4'(LAST_SAMPLE)) begin
                        p_err_d = rx_s ^ (^b_q);
                        state_d = STOP;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'(LAST_SAMPLE)) begin
                        data_d      = b_q;
                        ferr_d      = ~rx_s;
                        perr_d      = PARITY_EN ? p_err_q : 1'b0;
                        done_d      = 1'b1;
                        line_high_d = rx_s;
                        state_d     = IDLE;
                        s_d         = '0;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            p_err_q     <= 1'b0;
            line_high_q <= 1'b1;
            data_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            p_err_q     <= p_err_d;
            line_high_q <= line_high_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            done_q      <= done_d;
        end
    end

endmodule : uart_rx7

// File: tb/tb_uart_rx7.sv
// Self-checking bench for uart_rx7: frame-level model with expectation queues.
module tb_uart_rx7;

    localparam int CLK_DIV = 4;
    localparam int BIT_CLK = CLK_DIV * 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_np = 1'b1;
    logic [6:0] data_p, data_n;
    logic       done_p, done_n, perr_p, perr_n, ferr_p, ferr_n, busy_p, busy_n;

    uart_rx7 #(.CLK_DIV(CLK_DIV), .PARITY_EN(1'b1)) dut (
        .clk (clk), .reset_n (reset_n), .rx (rx), .data (data_p),
        .rx_done_tick (done_p), .parity_err (perr_p), .frame_err (ferr_p), .busy (busy_p)
    );

    uart_rx7 #(.CLK_DIV(CLK_DIV), .PARITY_EN(1'b0)) dut_np (
        .clk (clk), .reset_n (reset_n), .rx (rx_np), .data (data_n),
        .rx_done_tick (done_n), .parity_err (perr_n), .frame_err (ferr_n), .busy (busy_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One expected frame result: what the outputs must show and when.
    typedef struct {
        logic [6:0] data;
        logic       perr;
        logic       ferr;
        int         t0;
        int         lat;
    } exp_t;

    exp_t q_p[$];
    exp_t q_n[$];
    exp_t e_p, e_n;
    logic [6:0] hold_data_p = '0, hold_data_n = '0;
    logic hold_perr_p = 1'b0, hold_perr_n = 1'b0, hold_ferr_p = 1'b0, hold_ferr_n = 1'b0;
    int dones_p = 0, dones_n = 0;
    int last_done_p = 0, last_done_n = 0;
    int lat_p, lat_n;

    // Compare process for the parity-enabled receiver.
    always @(negedge clk) begin
        if (!reset_n) begin
            q_p.delete();
            hold_data_p = '0; hold_perr_p = 1'b0; hold_ferr_p = 1'b0;
        end else if (done_p) begin
            dones_p++;
            last_done_p = cyc;
            if (q_p.size() == 0) begin
                tests++; fails++;
                $display("FAIL done_p: unexpected pulse, data %0h (cycle %0d)", data_p, cyc);
            end else begin
                e_p = q_p.pop_front();
                lat_p = cyc - e_p.t0;
                check("data_p", data_p, e_p.data);
                check("perr_p", perr_p, e_p.perr);
                check("ferr_p", ferr_p, e_p.ferr);
                check("latency_p", 32'(lat_p >= e_p.lat - 2 && lat_p <= e_p.lat + 6), 1);
                hold_data_p = e_p.data; hold_perr_p = e_p.perr; hold_ferr_p = e_p.ferr;
            end
        end else begin
            check("hold_data_p", data_p, hold_data_p);
            check("hold_perr_p", perr_p, hold_perr_p);
            check("hold_ferr_p", ferr_p, hold_ferr_p);
        end
    end

    // Compare process for the no-parity receiver.
    always @(negedge clk) begin
        if (!reset_n) begin
            q_n.delete();
            hold_data_n = '0; hold_perr_n = 1'b0; hold_ferr_n = 1'b0;
        end else if (done_n) begin
            dones_n++;
            last_done_n = cyc;
            if (q_n.size() == 0) begin
                tests++; fails++;
                $display("FAIL done_n: unexpected pulse, data %0h (cycle %0d)", data_n, cyc);
            end else begin
                e_n = q_n.pop_front();
                lat_n = cyc - e_n.t0;
                check("data_n", data_n, e_n.data);
                check("perr_n", perr_n, e_n.perr);
                check("ferr_n", ferr_n, e_n.ferr);
                check("latency_n", 32'(lat_n >= e_n.lat - 2 && lat_n <= e_n.lat + 6), 1);
                hold_data_n = e_n.data; hold_perr_n = e_n.perr; hold_ferr_n = e_n.ferr;
            end
        end else begin
            check("hold_data_n", data_n, hold_data_n);
            check("hold_perr_n", perr_n, hold_perr_n);
            check("hold_ferr_n", ferr_n, hold_ferr_n);
        end
    end

    // Send one frame on line 'which' (0 = parity DUT, 1 = no-parity DUT).
    // reset_bit >= 0 pulses reset_n halfway through that bit and abandons the frame.
    task automatic send(input int which, input logic [6:0] d, input logic par_bit,
                        input logic stop_bit, input bit with_par, input bit expect_done,
                        input int reset_bit);
        logic [9:0] fr;
        int   nb;
        exp_t e;
        fr = '0;
        fr[0] = 1'b0;
        for (int i = 0; i < 7; i++) fr[1 + i] = d[i];
        if (with_par) begin
            fr[8] = par_bit; fr[9] = stop_bit; nb = 10;
        end else begin
            fr[8] = stop_bit; nb = 9;
        end
        @(negedge clk);
        if (expect_done) begin
            e.data = d;
            e.perr = with_par ? (par_bit ^ (^d)) : 1'b0;
            e.ferr = ~stop_bit;
            e.t0   = cyc;
            e.lat  = CLK_DIV * (8 + 16 * (8 + (with_par ? 1 : 0))) + 2;
            if (which == 0) q_p.push_back(e); else q_n.push_back(e);
        end
        for (int i = 0; i < nb; i++) begin
            if (which == 0) rx = fr[i]; else rx_np = fr[i];
            if (i == reset_bit) begin
                repeat (BIT_CLK / 2) @(negedge clk);
                #1 reset_n = 1'b0;
                #1;
                check("rst_data", data_p, 0);
                check("rst_done", done_p, 0);
                check("rst_perr", perr_p, 0);
                check("rst_ferr", ferr_p, 0);
                check("rst_busy", busy_p, 0);
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                if (which == 0) rx = 1'b1; else rx_np = 1'b1;
                return;
            end
            if (i == 3) check("busy_mid", (which == 0) ? busy_p : busy_n, 1);
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data", data_p, 0);
        check("reset_done", done_p, 0);
        check("reset_perr", perr_p, 0);
        check("reset_ferr", ferr_p, 0);
        check("reset_busy", busy_p, 0);
        check("reset_busy_np", busy_n, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", busy_p, 0);

        // 'A' with correct parity.
        send(0, 7'h41, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        check("A_data", data_p, 7'h41);
        check("A_perr", perr_p, 0);
        check("A_ferr", ferr_p, 0);
        repeat (10) @(negedge clk);
        check("A_busy_after", busy_p, 0);
        check("A_dones", dones_p, 1);

        // 'C' with wrong parity bit.
        send(0, 7'h43, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        check("C_data", data_p, 7'h43);
        check("C_perr", perr_p, 1);
        check("C_ferr", ferr_p, 0);

        // 0x55 with the stop bit low, then the line stays low.
        send(0, 7'h55, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        check("55_data", data_p, 7'h55);
        check("55_ferr", ferr_p, 1);
        check("55_perr", perr_p, 0);
        repeat (800) @(negedge clk);
        check("55_no_rearm_dones", dones_p, 3);
        check("55_no_rearm_busy", busy_p, 0);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        send(0, 7'h12, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        check("12_data", data_p, 7'h12);
        check("12_ferr", ferr_p, 0);
        check("12_dones", dones_p, 4);

        // Short low glitch: a false start only.
        @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_busy", busy_p, 1);
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_idle", busy_p, 0);
        check("glitch_dones", dones_p, 4);
        check("glitch_data", data_p, 7'h12);

        // Back-to-back pair on both receivers, started together.
        fork
            begin
                send(0, 7'h7F, 1'b1, 1'b1, 1'b1, 1'b1, -1);
                send(0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1, -1);
            end
            begin
                send(1, 7'h7F, 1'b0, 1'b1, 1'b0, 1'b1, -1);
                send(1, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1, -1);
            end
        join
        repeat (10) @(negedge clk);
        check("b2b_dones_p", dones_p, 6);
        check("b2b_dones_n", dones_n, 2);
        check("b2b_data_p", data_p, 7'h00);
        check("b2b_np_earlier", last_done_p - last_done_n, 2 * BIT_CLK);

        // Reset in the middle of the data bits of 0x2A, then a clean 0x2A.
        send(0, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b0, 4);
        repeat (100) @(negedge clk);
        check("post_reset_dones", dones_p, 6);
        send(0, 7'h2A, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        check("2A_data", data_p, 7'h2A);
        check("2A_perr", perr_p, 0);
        check("2A_ferr", ferr_p, 0);
        check("2A_dones", dones_p, 7);

        repeat (20) @(negedge clk);
        check("queue_p_empty", q_p.size(), 0);
        check("queue_n_empty", q_n.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_rx7
